// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out framer: FSM state
// encoding and the default parallel word width.
package piso_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bit_counter.sv
// Loadable down-counter with a zero flag. It saturates at zero, so a frame
// counter can never wrap past its last bit.
module bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/piso_framer.sv
// Serializes parallel words into back-to-back frames on x, with a one-word
// hold buffer so a following word can be accepted while a frame is shifting.
module piso_framer
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             ready_q, ready_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             fs_q, fs_d;

    logic             xfer;
    logic             load_frame;
    logic [WIDTH-1:0] load_word;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CW-1:0]    cnt;

    assign xfer = din_valid && ready_q;

    bit_counter #(
        .CW (CW)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_frame),
        .load_val_i (CW'(WIDTH - 1)),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // The first bit of a frame goes straight to x at the load edge, so the
    // shift register holds the word already advanced by one position.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        x_d         = x_q;
        x_valid_d   = x_valid_q;
        fs_d        = 1'b0;
        load_frame  = 1'b0;
        load_word   = din;
        cnt_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    load_frame = 1'b1;
                    load_word  = din;
                end
            end
            SHIFT: begin
                if (!cnt_zero) begin
                    x_d     = out_bit(shreg_q);
                    shreg_d = shift_word(shreg_q);
                    cnt_dec = 1'b1;
                    if (xfer) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    load_frame  = 1'b1;
                    load_word   = hold_q;
                    hold_full_d = 1'b0;
                end else if (xfer) begin
                    load_frame = 1'b1;
                    load_word  = din;
                end else begin
                    state_d   = IDLE;
                    shreg_d   = '0;
                    x_d       = 1'b0;
                    x_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_frame) begin
            state_d   = SHIFT;
            x_d       = out_bit(load_word);
            shreg_d   = shift_word(load_word);
            x_valid_d = 1'b1;
            fs_d      = 1'b1;
        end

        ready_d = !hold_full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            fs_q        <= fs_d;
        end
    end

    assign din_ready   = ready_q;
    assign x           = x_q;
    assign x_valid     = x_valid_q;
    assign frame_start = fs_q;
    assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_framer.sv
// Directed bench for piso_framer: MSB- and LSB-first framing, hold buffer,
// same-edge reload, asynchronous reset and a downstream 3-flop shift chain.
module tb_piso_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0, din1;
    logic       dv0, dv1;
    logic       rdy0, x0, xv0, fs0, busy0;
    logic       rdy1, x1, xv1, fs1, busy1;
    logic [2:0] ds;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    piso_framer #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
        .x(x0), .x_valid(xv0), .frame_start(fs0), .busy(busy0)
    );

    piso_framer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
        .x(x1), .x_valid(xv1), .frame_start(fs1), .busy(busy1)
    );

    // Downstream serial shift stage fed by x
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ds <= '0;
        else     ds <= {ds[1:0], x0};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0]  seq8;
    logic [15:0] seq16;

    initial begin
        rst = 1'b0; din0 = '0; dv0 = 1'b0; din1 = '0; dv1 = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("rst_x", x0, 0);
        chk("rst_xv", xv0, 0);
        chk("rst_fs", fs0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_ready_lsb", rdy1, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // LSB-first 0x01, transferred on the first edge after reset release
        seq8 = 8'b1000_0000;
        din1 = 8'h01; dv1 = 1'b1;
        @(negedge clk); dv1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("lsb_x", x1, seq8[7-k]);
            chk("lsb_xv", xv1, 1);
            chk("lsb_fs", fs1, (k == 0));
            @(negedge clk);
        end
        chk("lsb_end_xv", xv1, 0);
        chk("lsb_end_busy", busy1, 0);

        // MSB-first 0xA5 single frame, plus the downstream chain
        seq8 = 8'b1010_0101;
        din0 = 8'hA5; dv0 = 1'b1;
        @(negedge clk); dv0 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) begin
                chk("a5_x", x0, seq8[7-k]);
                chk("a5_xv", xv0, 1);
                chk("a5_fs", fs0, (k == 0));
                chk("a5_busy", busy0, 1);
            end else begin
                chk("a5_idle_xv", xv0, 0);
                chk("a5_idle_x", x0, 0);
                chk("a5_idle_fs", fs0, 0);
            end
            if (k >= 3) chk("chain_out", ds[2], seq8[7-(k-3)]);
            @(negedge clk);
        end

        // 0xF0 then 0x0F accepted into the hold register during frame 1
        seq16 = 16'b1111_0000_0000_1111;
        din0 = 8'hF0; dv0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            if (k < 16) begin
                chk("hold_x", x0, seq16[15-k]);
                chk("hold_xv", xv0, 1);
                chk("hold_fs", fs0, (k == 0 || k == 8));
                chk("hold_ready", rdy0, (k == 0 || k >= 8));
            end else begin
                chk("hold_end_xv", xv0, 0);
            end
            din0 = 8'h0F; dv0 = (k == 0);
            @(negedge clk);
        end

        // 0xFF, then 0x3C transferred on the edge ending the last bit
        seq16 = 16'b1111_1111_0011_1100;
        din0 = 8'hFF; dv0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            if (k < 16) begin
                chk("direct_x", x0, seq16[15-k]);
                chk("direct_xv", xv0, 1);
                chk("direct_fs", fs0, (k == 0 || k == 8));
                chk("direct_ready", rdy0, 1);
            end else begin
                chk("direct_end_xv", xv0, 0);
            end
            din0 = 8'h3C; dv0 = (k == 7);
            @(negedge clk);
        end

        // Reset during bit 4 of 0xAA with 0x55 held
        din0 = 8'hAA; dv0 = 1'b1;
        @(negedge clk);
        din0 = 8'h55; dv0 = 1'b1;
        @(negedge clk); dv0 = 1'b0;
        chk("arst_held_ready", rdy0, 0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("arst_bit4_x", x0, 1);
        chk("arst_bit4_xv", xv0, 1);
        rst = 1'b1;
        #1;
        chk("arst_x", x0, 0);
        chk("arst_xv", xv0, 0);
        chk("arst_fs", fs0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_ready", rdy0, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("post_rst_xv", xv0, 0);
            chk("post_rst_busy", busy0, 0);
            @(negedge clk);
        end
        din0 = 8'h3C; dv0 = 1'b1;
        @(negedge clk); dv0 = 1'b0;
        chk("restart_fs", fs0, 1);
        chk("restart_xv", xv0, 1);
        chk("restart_x", x0, 0);
        @(negedge clk); @(negedge clk);
        chk("restart_x2", x0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
